freq_bram_arbiter: RTL

Controller that owns both ports of the dual-port frequency-bin BRAM (1-cycle registered read, separate read/write ports, single clock domain here). Shares the read port between the SDFT update engine (requester A, high priority) and the bin readout path (requester B, e.g. display/UART dump). Gives the write port to A. Also runs a clear sequencer that zeroes every bin, and forwards write data on same-address read-during-write.

---
 rtl/freq_bram_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/freq_bram_arbiter.sv
// freq_bram_arbiter
//   Owns both ports of the dual-port frequency-bin BRAM (1-cycle registered
//   read, old data returned on same-address read-during-write).
//   - Read port shared between A (SDFT engine, priority) and B (readout),
//     with a starvation limit that forces a B grant after STARVE_MAX
//     consecutive contested A wins.
//   - Write port belongs to A, except during the clear sequence, which
//     writes CLEAR_VALUE to every bin, one per cycle.
//   - Same-cycle read/write to one address forwards the write data.
// Ports
//   clk, reset_n            clock, async active-low reset
//   clear / busy            start clear pulse / clear in progress
//   a_req,a_addr,a_gnt      A read request/address/grant
//   a_rvalid,a_rdata        A read response (cycle after grant)
//   a_wen,a_waddr,a_wdata   A write request, a_wready = accepted
//   b_req,b_addr,b_gnt      B read request/address/grant
//   b_rvalid,b_rdata        B read response
//   bram_*                  BRAM read/write port pins
module freq_bram_arbiter #(
  parameter int                 addr_w      = 7,
  parameter int                 data_w      = 8,
  parameter int                 STARVE_MAX  = 4,
  parameter logic [data_w-1:0]  CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  output logic              busy,
  input  logic              a_req,
  input  logic [addr_w-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [data_w-1:0] a_rdata,
  input  logic              a_wen,
  input  logic [addr_w-1:0] a_waddr,
  input  logic [data_w-1:0] a_wdata,
  output logic              a_wready,
  input  logic              b_req,
  input  logic [addr_w-1:0] b_addr,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [data_w-1:0] b_rdata,
  output logic              bram_r_en,
  output logic [addr_w-1:0] bram_r_addr,
  output logic              bram_w_en,
  output logic [addr_w-1:0] bram_w_addr,
  output logic [data_w-1:0] bram_d_in,
  input  logic [data_w-1:0] bram_d_out
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              r_state, w_next;
  logic [SW-1:0]       r_starve;
  logic [addr_w-1:0]   r_clr_addr;
  logic                r_a_rvalid, r_b_rvalid;
  logic                r_fwd;
  logic [data_w-1:0]   r_fwd_data;
  logic                w_force_b;
  logic                w_rd_hit;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (clear) w_next = S_CLEAR;
      S_CLEAR: if (r_clr_addr == {addr_w{1'b1}}) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // B wins contention once A has taken STARVE_MAX contested cycles in a row
  assign w_force_b = (r_starve == SW'(STARVE_MAX));

  // ---------------- FSM: outputs ----------------
  // Everything here is gated by reset_n so the BRAM sees no activity while
  // reset is held.
  always_comb begin
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    bram_r_en   = 1'b0;
    bram_r_addr = '0;
    bram_w_en   = 1'b0;
    bram_w_addr = '0;
    bram_d_in   = '0;
    busy        = 1'b0;
    if (reset_n) begin
      case (r_state)
        S_IDLE: begin
          a_gnt = a_req & ~(b_req & w_force_b);
          b_gnt = b_req & (~a_req | w_force_b);
          bram_r_en = a_gnt | b_gnt;
          if (b_gnt)      bram_r_addr = b_addr;
          else if (a_gnt) bram_r_addr = a_addr;
          bram_w_en   = a_wen;
          bram_w_addr = a_waddr;
          bram_d_in   = a_wdata;
        end
        S_CLEAR: begin
          busy        = 1'b1;
          bram_w_en   = 1'b1;
          bram_w_addr = r_clr_addr;
          bram_d_in   = CLEAR_VALUE;
        end
        default: ;
      endcase
    end
  end

  assign a_wready = ~busy;

  // BRAM returns old data on same-address read-during-write; remember the
  // new data so the requester sees it instead.
  assign w_rd_hit = bram_r_en & bram_w_en & (bram_r_addr == bram_w_addr);

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
      r_starve   <= '0;
      r_clr_addr <= '0;
    end else begin
      r_a_rvalid <= a_gnt;
      r_b_rvalid <= b_gnt;
      r_fwd      <= w_rd_hit;
      if (w_rd_hit) r_fwd_data <= bram_d_in;

      // A contested A win can only happen below STARVE_MAX, so no saturation
      if (a_gnt & b_req)        r_starve <= r_starve + SW'(1);
      else if (b_gnt | ~b_req)  r_starve <= '0;

      // counter wraps to 0 after the last bin, ready for the next clear
      if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + addr_w'(1);
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_fwd ? r_fwd_data : bram_d_out;
  assign b_rdata  = r_fwd ? r_fwd_data : bram_d_out;

endmodule
